// File: rtl/reference_model.sv
// Register-access decoder and byte-pointer tracker for an 8237-style DMA controller.
// Optional feature: define REF_MODEL_TEMP_READ_EN to decode temporary-register reads at 0xD.
module reference_model (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       programCondition,
   input  logic       CS_N,
   input  logic       IOR_N,
   input  logic       IOW_N,
   input  logic       A3,
   input  logic       A2,
   input  logic       A1,
   input  logic       A0,
   output logic       loadCommandReg,
   output logic       loadModeReg,
   output logic       loadRequestReg,
   output logic       loadSingleMask,
   output logic       loadAllMask,
   output logic       clearMask,
   output logic       masterClear,
   output logic       clearInternalFF,
   output logic       loadBaseAddressReg,
   output logic       loadBaseWordCountReg,
   output logic       readStatusReg,
   output logic       readTemporaryReg,
   output logic       readCurrentAddressReg,
   output logic       readCurrentWordCountReg,
   output logic       loadIoDataBufferFromStatus,
   output logic [1:0] channelSel,
   output logic       enUpperAddress,
   output logic       accessError
);

   logic [3:0] addr;
   logic       raw_active, valid, wr, rd, chan_valid, access_end;
   logic       byte_ptr_q, byte_ptr_d;
   logic       chan_pend_q, chan_pend_d;
   logic       status_q, status_d;
   logic       status_pulse_q, status_pulse_d;

   assign addr        = {A3, A2, A1, A0};
   assign accessError = !CS_N && !IOR_N && !IOW_N;
   // Strobe activity ignores programCondition so an access end is still seen after it falls.
   assign raw_active  = !CS_N && (IOR_N ^ IOW_N);
   assign valid       = programCondition && raw_active;
   assign wr          = valid && !IOW_N;
   assign rd          = valid && !IOR_N;
   assign chan_valid  = valid && !A3;
   assign channelSel  = chan_valid ? {A2, A1} : 2'b00;

   always_comb begin
      loadCommandReg          = 1'b0;
      loadModeReg             = 1'b0;
      loadRequestReg          = 1'b0;
      loadSingleMask          = 1'b0;
      loadAllMask             = 1'b0;
      clearMask               = 1'b0;
      masterClear             = 1'b0;
      clearInternalFF         = 1'b0;
      loadBaseAddressReg      = 1'b0;
      loadBaseWordCountReg    = 1'b0;
      readStatusReg           = 1'b0;
      readTemporaryReg        = 1'b0;
      readCurrentAddressReg   = 1'b0;
      readCurrentWordCountReg = 1'b0;
      if (chan_valid) begin
         loadBaseAddressReg      = wr && !A0;
         loadBaseWordCountReg    = wr && A0;
         readCurrentAddressReg   = rd && !A0;
         readCurrentWordCountReg = rd && A0;
      end else if (wr) begin
         case (addr)
            4'h8:    loadCommandReg  = 1'b1;
            4'h9:    loadRequestReg  = 1'b1;
            4'hA:    loadSingleMask  = 1'b1;
            4'hB:    loadModeReg     = 1'b1;
            4'hC:    clearInternalFF = 1'b1;
            4'hD:    masterClear     = 1'b1;
            4'hE:    clearMask       = 1'b1;
            4'hF:    loadAllMask     = 1'b1;
            default: ;
         endcase
      end else if (rd) begin
         case (addr)
            4'h8:    readStatusReg    = 1'b1;
`ifdef REF_MODEL_TEMP_READ_EN
            4'hD:    readTemporaryReg = 1'b1;
`endif
            default: ;
         endcase
      end
   end

   // Pending toggle reflects validity of the most recent active cycle of a channel access.
   assign chan_pend_d    = raw_active ? chan_valid : 1'b0;
   assign access_end     = chan_pend_q && !raw_active;
   assign byte_ptr_d     = (clearInternalFF || masterClear) ? 1'b0 : (byte_ptr_q ^ access_end);
   assign status_d       = readStatusReg;
   assign status_pulse_d = readStatusReg && !status_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         byte_ptr_q     <= 1'b0;
         chan_pend_q    <= 1'b0;
         status_q       <= 1'b0;
         status_pulse_q <= 1'b0;
      end else begin
         byte_ptr_q     <= byte_ptr_d;
         chan_pend_q    <= chan_pend_d;
         status_q       <= status_d;
         status_pulse_q <= status_pulse_d;
      end
   end

   assign enUpperAddress             = byte_ptr_q;
   assign loadIoDataBufferFromStatus = status_pulse_q;

endmodule

// File: tb/tb_reference_model.sv
// Self-checking bench for reference_model: directed scenarios plus randomized accesses
// checked against a transaction-level model of the decode table and byte pointer.
module tb_reference_model;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       programCondition = 1'b0;
   logic       CS_N = 1'b1, IOR_N = 1'b1, IOW_N = 1'b1;
   logic       A3 = 1'b0, A2 = 1'b0, A1 = 1'b0, A0 = 1'b0;
   logic       loadCommandReg, loadModeReg, loadRequestReg, loadSingleMask, loadAllMask;
   logic       clearMask, masterClear, clearInternalFF, loadBaseAddressReg;
   logic       loadBaseWordCountReg, readStatusReg, readTemporaryReg;
   logic       readCurrentAddressReg, readCurrentWordCountReg, loadIoDataBufferFromStatus;
   logic [1:0] channelSel;
   logic       enUpperAddress, accessError;
   logic [13:0] dec;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   reference_model dut (
      .CLK                       (CLK),
      .RESET_N                   (RESET_N),
      .programCondition          (programCondition),
      .CS_N                      (CS_N),
      .IOR_N                     (IOR_N),
      .IOW_N                     (IOW_N),
      .A3                        (A3),
      .A2                        (A2),
      .A1                        (A1),
      .A0                        (A0),
      .loadCommandReg            (loadCommandReg),
      .loadModeReg               (loadModeReg),
      .loadRequestReg            (loadRequestReg),
      .loadSingleMask            (loadSingleMask),
      .loadAllMask               (loadAllMask),
      .clearMask                 (clearMask),
      .masterClear               (masterClear),
      .clearInternalFF           (clearInternalFF),
      .loadBaseAddressReg        (loadBaseAddressReg),
      .loadBaseWordCountReg      (loadBaseWordCountReg),
      .readStatusReg             (readStatusReg),
      .readTemporaryReg          (readTemporaryReg),
      .readCurrentAddressReg     (readCurrentAddressReg),
      .readCurrentWordCountReg   (readCurrentWordCountReg),
      .loadIoDataBufferFromStatus(loadIoDataBufferFromStatus),
      .channelSel                (channelSel),
      .enUpperAddress            (enUpperAddress),
      .accessError               (accessError)
   );

   // Bit order used for expected decode vectors below.
   assign dec = {loadCommandReg, loadModeReg, loadRequestReg, loadSingleMask, loadAllMask,
                 clearMask, masterClear, clearInternalFF, loadBaseAddressReg,
                 loadBaseWordCountReg, readStatusReg, readTemporaryReg,
                 readCurrentAddressReg, readCurrentWordCountReg};

   function automatic logic [13:0] exp_dec(input logic [3:0] a, input logic is_wr,
                                           input logic v);
      logic [13:0] e;
      e = '0;
      if (v) begin
         if (!a[3]) begin
            if (is_wr) e[a[0] ? 4 : 5] = 1'b1;
            else       e[a[0] ? 0 : 1] = 1'b1;
         end else if (is_wr) begin
            case (a)
               4'h8: e[13] = 1'b1;
               4'h9: e[11] = 1'b1;
               4'hA: e[10] = 1'b1;
               4'hB: e[12] = 1'b1;
               4'hC: e[6]  = 1'b1;
               4'hD: e[7]  = 1'b1;
               4'hE: e[8]  = 1'b1;
               default: e[9] = 1'b1;
            endcase
         end else begin
            if (a == 4'h8) e[3] = 1'b1;
`ifdef REF_MODEL_TEMP_READ_EN
            if (a == 4'hD) e[2] = 1'b1;
`endif
         end
      end
      return e;
   endfunction

   // Advance to just after the next rising edge and apply new inputs.
   task automatic drive(input logic cs, input logic ior, input logic iow, input logic [3:0] a,
                        input logic prog);
      @(posedge CLK);
      #1;
      CS_N = cs; IOR_N = ior; IOW_N = iow;
      {A3, A2, A1, A0} = a;
      programCondition = prog;
      #3;
   endtask

   task automatic test_reset;
      RESET_N = 1'b0;
      #12;
      checks++;
      if (enUpperAddress !== 1'b0 || loadIoDataBufferFromStatus !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: ff=%b pulse=%b required 0 0", enUpperAddress,
                  loadIoDataBufferFromStatus);
      end
      checks++;
      if (dec !== 14'h0 || channelSel !== 2'b00 || accessError !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: dec=%h sel=%0d err=%b required 0 0 0", dec, channelSel,
                  accessError);
      end
      #1 RESET_N = 1'b1;
   endtask

   task automatic test_command_write;
      drive(1'b0, 1'b1, 1'b0, 4'h8, 1'b1);
      checks++;
      if (dec !== 14'h2000) begin
         failures++;
         $display("FAIL cmd_write: dec=%h required %h", dec, 14'h2000);
      end
      drive(1'b1, 1'b1, 1'b0, 4'h8, 1'b1);
      checks++;
      if (dec !== 14'h0) begin
         failures++;
         $display("FAIL cmd_deselect: dec=%h required 0", dec);
      end
      drive(1'b1, 1'b1, 1'b1, 4'h0, 1'b1);
   endtask

   task automatic test_status_read;
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 1'b1, 4'h8, 1'b1);
         checks++;
         if (readStatusReg !== 1'b1 || loadIoDataBufferFromStatus !== (k == 1)) begin
            failures++;
            $display("FAIL status_read cycle %0d: rs=%b pulse=%b required 1 %b", k,
                     readStatusReg, loadIoDataBufferFromStatus, k == 1);
         end
      end
      drive(1'b1, 1'b1, 1'b1, 4'h0, 1'b1);
      checks++;
      if (readStatusReg !== 1'b0 || loadIoDataBufferFromStatus !== 1'b0) begin
         failures++;
         $display("FAIL status_end: rs=%b pulse=%b required 0 0", readStatusReg,
                  loadIoDataBufferFromStatus);
      end
   endtask

   task automatic test_byte_pointer;
      logic exp_ff[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic is_wr[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int k = 0; k < 6; k++) begin
         drive(!is_wr[k], 1'b1, !is_wr[k], 4'h2, 1'b1);
         checks++;
         if (enUpperAddress !== exp_ff[k] || loadBaseAddressReg !== is_wr[k] ||
             channelSel !== (is_wr[k] ? 2'd1 : 2'd0)) begin
            failures++;
            $display("FAIL byte_ptr step %0d: ff=%b lba=%b sel=%0d required %b %b %0d", k,
                     enUpperAddress, loadBaseAddressReg, channelSel, exp_ff[k], is_wr[k],
                     is_wr[k] ? 1 : 0);
         end
      end
   endtask

   task automatic test_clear;
      logic [3:0] clr_addr[2] = '{4'hC, 4'hD};
      for (int j = 0; j < 2; j++) begin
         drive(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
         drive(1'b1, 1'b1, 1'b1, 4'h0, 1'b1);
         drive(1'b1, 1'b1, 1'b1, 4'h0, 1'b1);
         checks++;
         if (enUpperAddress !== 1'b1) begin
            failures++;
            $display("FAIL clear_setup %0d: ff=%b required 1", j, enUpperAddress);
         end
         drive(1'b0, 1'b1, 1'b0, clr_addr[j], 1'b1);
         checks++;
         if (dec !== (j == 0 ? 14'h0040 : 14'h0080)) begin
            failures++;
            $display("FAIL clear_decode %0d: dec=%h required %h", j, dec,
                     j == 0 ? 14'h0040 : 14'h0080);
         end
         drive(1'b1, 1'b1, 1'b1, 4'h0, 1'b1);
         checks++;
         if (enUpperAddress !== 1'b0) begin
            failures++;
            $display("FAIL clear_ff %0d: ff=%b required 0", j, enUpperAddress);
         end
      end
   endtask

   task automatic test_prog_gate;
      drive(1'b0, 1'b1, 1'b0, 4'hB, 1'b0);
      checks++;
      if (dec !== 14'h0 || loadModeReg !== 1'b0) begin
         failures++;
         $display("FAIL prog_gate_mode: dec=%h required 0", dec);
      end
      drive(1'b0, 1'b1, 1'b0, 4'h1, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 4'h0, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 4'h0, 1'b1);
      checks++;
      if (enUpperAddress !== 1'b0) begin
         failures++;
         $display("FAIL prog_gate_chan: ff=%b required 0", enUpperAddress);
      end
      // programCondition drops on the last cycle of a channel write: no toggle.
      drive(1'b0, 1'b1, 1'b0, 4'h1, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 4'h1, 1'b0);
      checks++;
      if (dec !== 14'h0 || channelSel !== 2'b00) begin
         failures++;
         $display("FAIL prog_fall_decode: dec=%h sel=%0d required 0 0", dec, channelSel);
      end
      drive(1'b1, 1'b1, 1'b1, 4'h0, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 4'h0, 1'b1);
      checks++;
      if (enUpperAddress !== 1'b0) begin
         failures++;
         $display("FAIL prog_fall_ff: ff=%b required 0", enUpperAddress);
      end
   endtask

   task automatic test_access_error;
      for (int p = 0; p < 2; p++) begin
         drive(1'b0, 1'b0, 1'b0, 4'h8, p[0]);
         checks++;
         if (accessError !== 1'b1 || dec !== 14'h0 || channelSel !== 2'b00) begin
            failures++;
            $display("FAIL access_error prog=%0d: err=%b dec=%h required 1 0", p, accessError,
                     dec);
         end
      end
      drive(1'b1, 1'b0, 1'b0, 4'h8, 1'b1);
      checks++;
      if (accessError !== 1'b0) begin
         failures++;
         $display("FAIL access_error_cs: err=%b required 0", accessError);
      end
      drive(1'b1, 1'b1, 1'b1, 4'h0, 1'b1);
   endtask

   task automatic test_reset_mid_access;
      drive(1'b0, 1'b1, 1'b0, 4'h5, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 4'h0, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 4'h5, 1'b1);
      checks++;
      if (enUpperAddress !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_setup: ff=%b required 1", enUpperAddress);
      end
      RESET_N = 1'b0;
      #1;
      checks++;
      if (enUpperAddress !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_async: ff=%b required 0", enUpperAddress);
      end
      CS_N = 1'b1; IOW_N = 1'b1;
      #2 RESET_N = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 4'h0, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 4'h0, 1'b1);
      checks++;
      if (enUpperAddress !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_discard: ff=%b required 0", enUpperAddress);
      end
   endtask

   task automatic test_random;
      logic       model_ff;
      logic [3:0] a;
      logic       is_wr, prog, is_status;
      int         len;
      logic [13:0] e;
      logic [1:0]  e_sel;
      RESET_N = 1'b0;
      #3 RESET_N = 1'b1;
      model_ff = 1'b0;
      for (int n = 0; n < 80; n++) begin
         a         = 4'($urandom_range(0, 15));
         is_wr     = 1'($urandom_range(0, 1));
         prog      = ($urandom_range(0, 3) != 0);
         len       = $urandom_range(1, 3);
         e         = exp_dec(a, is_wr, prog);
         e_sel     = (prog && !a[3]) ? a[2:1] : 2'b00;
         is_status = prog && !is_wr && (a == 4'h8);
         for (int k = 0; k < len; k++) begin
            drive(1'b0, is_wr, !is_wr, a, prog);
            checks++;
            if (dec !== e || channelSel !== e_sel || enUpperAddress !== model_ff ||
                loadIoDataBufferFromStatus !== (is_status && k == 1) || accessError !== 1'b0)
            begin
               failures++;
               $display("FAIL rand %0d a=%h wr=%b prog=%b cyc=%0d: dec=%h sel=%0d ff=%b pulse=%b required %h %0d %b %b",
                        n, a, is_wr, prog, k, dec, channelSel, enUpperAddress,
                        loadIoDataBufferFromStatus, e, e_sel, model_ff, is_status && k == 1);
            end
            if (prog && is_wr && (a == 4'hC || a == 4'hD)) model_ff = 1'b0;
         end
         drive(1'b1, 1'b1, 1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         checks++;
         if (dec !== 14'h0 || enUpperAddress !== model_ff ||
             loadIoDataBufferFromStatus !== (is_status && len == 1)) begin
            failures++;
            $display("FAIL rand_idle %0d: dec=%h ff=%b pulse=%b required 0 %b %b", n, dec,
                     enUpperAddress, loadIoDataBufferFromStatus, model_ff,
                     is_status && len == 1);
         end
         if (prog && !a[3]) model_ff = !model_ff;
      end
   endtask

   initial begin
      test_reset();
      test_command_write();
      test_status_read();
      test_byte_pointer();
      test_clear();
      test_prog_gate();
      test_access_error();
      test_reset_mid_access();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reference_model.md
# reference_model

Cycle-accurate register-access decoder for the 8237-style DMA controller, used as the golden model beside the DMA core in formal and simulation benches. From chip select, I/O read/write strobes and the low four address bits it produces the internal load/read strobes that the DMA's register file must act on. It also tracks the byte-pointer flip-flop so checkers can predict low/high byte accesses.

## Interface
- No parameters.
- CLK  input  1  system clock, rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- programCondition  input  1  high when the DMA is idle and the CPU may program it; all decoding gated by it.
- CS_N  input  1  chip select, active low.
- IOR_N  input  1  I/O read strobe, active low.
- IOW_N  input  1  I/O write strobe, active low.
- A3, A2, A1, A0  input  1 each  register address bits.
- loadCommandReg, loadModeReg, loadRequestReg, loadSingleMask, loadAllMask, clearMask, masterClear, clearInternalFF  output  1 each  write decodes.
- loadBaseAddressReg, loadBaseWordCountReg  output  1 each  channel address/count writes (base and current loaded together).
- readStatusReg, readTemporaryReg, readCurrentAddressReg, readCurrentWordCountReg  output  1 each  read decodes.
- loadIoDataBufferFromStatus  output  1  registered status-read pulse.
- channelSel  output  2  {A2,A1} for channel register accesses, else 0.
- enUpperAddress  output  1  byte-pointer flip-flop state (0 = low byte, 1 = high byte).
- accessError  output  1  IOR_N and IOW_N both low while selected.

## Operation
- Access valid = programCondition & !CS_N & exactly one of IOR_N/IOW_N low. All decode outputs 0 otherwise.
- A3=0 (channel regs): A0=0 -> write: loadBaseAddressReg; read: readCurrentAddressReg. A0=1 -> write: loadBaseWordCountReg; read: readCurrentWordCountReg. channelSel = {A2,A1}.
- A3=1, write: 8 loadCommandReg, 9 loadRequestReg, A loadSingleMask, B loadModeReg, C clearInternalFF, D masterClear, E clearMask, F loadAllMask.
- A3=1, read: 8 readStatusReg, D readTemporaryReg; all other read addresses decode nothing.
- Decode outputs are combinational levels, asserted for every cycle the access is valid.
- Byte pointer flip-flop: toggles on the cycle after a valid A3=0 access ends (strobe rises or CS_N rises); cleared to 0 on clearInternalFF or masterClear (takes priority over toggle). enUpperAddress = flip-flop.
- accessError = !CS_N & !IOR_N & !IOW_N (independent of programCondition); when high all decodes are 0.

## Timing
- Reset: flip-flop 0, loadIoDataBufferFromStatus 0, edge-detect history = inactive; combinational outputs follow inputs (0 with no access).
- Decodes: zero latency; the DMA register is updated at the following rising edge (value visible one cycle later).
- loadIoDataBufferFromStatus: single-cycle pulse, one cycle after the first cycle readStatusReg is high; held-low IOR_N produces one pulse only.
- Flip-flop update: registered, visible one cycle after the access end condition.
- programCondition falling mid-access: decodes drop immediately; access end still toggles flip-flop only if the access was valid on its last valid cycle.
- RESET_N asserted mid-access: all registered state cleared asynchronously; pending toggle discarded.

## Configuration
- REF_MODEL_TEMP_READ_EN: defined -> read at address D asserts readTemporaryReg. Undefined -> readTemporaryReg tied 0 and read at D decodes nothing.

## Test plan
- CS_N=0, IOW_N=0, A=8, programCondition=1 -> loadCommandReg=1 same cycle, all other decodes 0; CS_N=1 -> 0.
- Read A=8 held 3 cycles -> readStatusReg=1 for 3 cycles; loadIoDataBufferFromStatus=1 exactly in cycle 2.
- Write A=2 twice -> loadBaseAddressReg, channelSel=1 each time; enUpperAddress 0 during first write, 1 during second, 0 afterwards.
- Write A=C after one A=0 write -> enUpperAddress returns to 0 next cycle; write A=D -> masterClear=1, flip-flop 0.
- programCondition=0 with valid write A=B -> loadModeReg=0, flip-flop unchanged.
- IOR_N=IOW_N=0, CS_N=0 -> accessError=1, all decodes 0; RESET_N=0 mid-access -> enUpperAddress=0 immediately.
